// File: rtl/regfile_scoreboard_if.sv
// Bundle of write-back, operand-read and issue-reservation signals shared
// between the register file scoreboard and its pipeline neighbours.
interface regfile_scoreboard_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
) ();
  localparam int AW = $clog2(NREGS);
  localparam int CW = $clog2(NREGS + 1);

  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [XLEN-1:0]   wr_data;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              iss_valid;
  logic [AW-1:0]     iss_rd;
  logic              iss_ready;
  logic [CW-1:0]     busy_cnt;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, iss_valid, iss_rd,
    input  rd_data, rd_busy, iss_ready, busy_cnt
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, iss_valid, iss_rd,
    output rd_data, rd_busy, iss_ready, busy_cnt
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// RISC-V integer register file with combinational read ports, write-to-read
// bypass and a per-register busy scoreboard used by issue to stall on RAW/WAW.
module regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input logic clk,
  input logic reset,
  regfile_scoreboard_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam int CW = $clog2(NREGS + 1);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;
  logic             wr_hit;
  logic             set_hit;
  logic             same_reg;
  logic             iss_ready;

  assign wr_hit    = bus.wr_en && (bus.wr_addr != '0);
  // A pending write retiring this cycle frees the destination for a new reservation.
  assign iss_ready = (bus.iss_rd == '0) || !busy[bus.iss_rd] ||
                     (bus.wr_en && (bus.wr_addr == bus.iss_rd));
  assign set_hit   = bus.iss_valid && iss_ready && (bus.iss_rd != '0);
  assign same_reg  = wr_hit && set_hit && (bus.wr_addr == bus.iss_rd);

  assign bus.iss_ready = iss_ready;
  assign bus.busy_cnt  = cnt;

  // The new reservation is applied after the release so it wins on a collision.
  always_comb begin
    busy_next = busy;
    cnt_next  = cnt;
    if (wr_hit)
      busy_next[bus.wr_addr] = 1'b0;
    if (set_hit)
      busy_next[bus.iss_rd] = 1'b1;
    if (set_hit && !busy[bus.iss_rd])
      cnt_next = cnt_next + CW'(1);
    if (wr_hit && busy[bus.wr_addr] && !same_reg)
      cnt_next = cnt_next - CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
      busy <= '0;
      cnt  <= '0;
    end else begin
      if (wr_hit)
        regs[bus.wr_addr] <= bus.wr_data;
      busy <= busy_next;
      cnt  <= cnt_next;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic          hit;

    assign addr = bus.rd_addr[k*AW +: AW];
    assign hit  = (BYPASS != 0) && bus.wr_en && (bus.wr_addr == addr);
    assign bus.rd_data[k*XLEN +: XLEN] = (addr == '0) ? '0 :
                                         hit          ? bus.wr_data : regs[addr];
    assign bus.rd_busy[k] = (addr != '0) && busy[addr] && !hit;
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: a bypassing and a non-bypassing
// instance see identical stimulus and are compared against hand-computed vectors.
module tb_regfile_scoreboard;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  regfile_scoreboard_if #(.XLEN(32), .NREGS(32), .NRD(2)) bus ();
  regfile_scoreboard_if #(.XLEN(32), .NREGS(32), .NRD(2)) bus_nb ();

  assign bus_nb.wr_en     = bus.wr_en;
  assign bus_nb.wr_addr   = bus.wr_addr;
  assign bus_nb.wr_data   = bus.wr_data;
  assign bus_nb.rd_addr   = bus.rd_addr;
  assign bus_nb.iss_valid = bus.iss_valid;
  assign bus_nb.iss_rd    = bus.iss_rd;

  regfile_scoreboard #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  regfile_scoreboard #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .bus(bus_nb)
  );

  typedef struct {
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [31:0] exp_d0;
    logic [31:0] exp_d1;
    logic [1:0]  exp_busy;
    logic        exp_ready;
    logic [5:0]  exp_cnt;
    logic [31:0] exp_d0n;
    logic [31:0] exp_d1n;
    logic [1:0]  exp_busyn;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic we, input logic [4:0] wa, input logic [31:0] wd,
    input logic [4:0] a0, input logic [4:0] a1,
    input logic iv, input logic [4:0] ir,
    input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] bz,
    input logic rdy, input logic [5:0] cn,
    input logic [31:0] d0n, input logic [31:0] d1n, input logic [1:0] bzn);
    vec_t v;
    v.wr_en = we;   v.wr_addr = wa; v.wr_data = wd;
    v.ra0 = a0;     v.ra1 = a1;
    v.iss_valid = iv; v.iss_rd = ir;
    v.exp_d0 = d0;  v.exp_d1 = d1;  v.exp_busy = bz;
    v.exp_ready = rdy; v.exp_cnt = cn;
    v.exp_d0n = d0n; v.exp_d1n = d1n; v.exp_busyn = bzn;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic apply_stimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic [4:0] a0, input logic [4:0] a1,
                                input logic iv, input logic [4:0] ir);
    bus.wr_en     = we;
    bus.wr_addr   = wa;
    bus.wr_data   = wd;
    bus.rd_addr   = {a1, a0};
    bus.iss_valid = iv;
    bus.iss_rd    = ir;
  endtask

  task automatic check_output(input string tag, input vec_t v);
    check({tag, " d0"},     64'(bus.rd_data[31:0]),     64'(v.exp_d0));
    check({tag, " d1"},     64'(bus.rd_data[63:32]),    64'(v.exp_d1));
    check({tag, " busy"},   64'(bus.rd_busy),           64'(v.exp_busy));
    check({tag, " ready"},  64'(bus.iss_ready),         64'(v.exp_ready));
    check({tag, " cnt"},    64'(bus.busy_cnt),          64'(v.exp_cnt));
    check({tag, " nb d0"},  64'(bus_nb.rd_data[31:0]),  64'(v.exp_d0n));
    check({tag, " nb d1"},  64'(bus_nb.rd_data[63:32]), 64'(v.exp_d1n));
    check({tag, " nb busy"},64'(bus_nb.rd_busy),        64'(v.exp_busyn));
  endtask

  initial begin
    // wr_en wa wd | ra0 ra1 | iv ir | d0 d1 busy ready cnt | nb d0 d1 busy
    vq.push_back(mk(0, 0, 0,            0, 5, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 2'b00));
    vq.push_back(mk(1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 32'hDEADBEEF, 0, 2'b00, 1, 0, 0, 0, 2'b00));
    vq.push_back(mk(1, 0, 32'h1234,     5, 0, 0, 0, 32'hDEADBEEF, 0, 2'b00, 1, 0, 32'hDEADBEEF, 0, 2'b00));
    vq.push_back(mk(1, 7, 32'hA5A5A5A5, 0, 7, 0, 0, 0, 32'hA5A5A5A5, 2'b00, 1, 0, 0, 0, 2'b00));
    vq.push_back(mk(0, 0, 0,            3, 7, 1, 3, 0, 32'hA5A5A5A5, 2'b00, 1, 0, 0, 32'hA5A5A5A5, 2'b00));
    vq.push_back(mk(0, 0, 0,            3, 5, 1, 3, 0, 32'hDEADBEEF, 2'b01, 0, 1, 0, 32'hDEADBEEF, 2'b01));
    vq.push_back(mk(1, 3, 32'h33,       3, 3, 1, 3, 32'h33, 32'h33, 2'b00, 1, 1, 0, 0, 2'b11));
    vq.push_back(mk(0, 0, 0,            3, 3, 0, 0, 32'h33, 32'h33, 2'b11, 1, 1, 32'h33, 32'h33, 2'b11));
    vq.push_back(mk(1, 3, 32'h44,       3, 0, 0, 0, 32'h44, 0, 2'b00, 1, 1, 32'h33, 0, 2'b01));
    vq.push_back(mk(0, 0, 0,            3, 0, 1, 0, 32'h44, 0, 2'b00, 1, 0, 32'h44, 0, 2'b00));
    vq.push_back(mk(1, 9, 32'h99,       9, 0, 1, 9, 32'h99, 0, 2'b00, 1, 0, 0, 0, 2'b00));
    vq.push_back(mk(0, 0, 0,            9, 3, 0, 0, 32'h99, 32'h44, 2'b01, 1, 1, 32'h99, 32'h44, 2'b01));
    vq.push_back(mk(1, 5, 32'h55,       5, 9, 0, 0, 32'h55, 32'h99, 2'b10, 1, 1, 32'hDEADBEEF, 32'h99, 2'b10));
    vq.push_back(mk(1, 9, 32'h999,      9, 5, 1, 9, 32'h999, 32'h55, 2'b00, 1, 1, 32'h99, 32'h55, 2'b01));
    vq.push_back(mk(0, 0, 0,            9, 9, 0, 0, 32'h999, 32'h999, 2'b11, 1, 1, 32'h999, 32'h999, 2'b11));
    vq.push_back(mk(1, 9, 0,            0, 9, 0, 0, 0, 0, 2'b00, 1, 1, 0, 32'h999, 2'b10));
    vq.push_back(mk(0, 0, 0,            9, 3, 0, 0, 0, 32'h44, 2'b00, 1, 0, 0, 32'h44, 2'b00));

    // Reset held: outputs must already be cleared with no clock edge.
    reset = 1'b1;
    apply_stimulus(0, 0, 0, 5, 9, 0, 0);
    #1;
    check("reset d0",    64'(bus.rd_data),   64'd0);
    check("reset busy",  64'(bus.rd_busy),   64'd0);
    check("reset ready", 64'(bus.iss_ready), 64'd1);
    check("reset cnt",   64'(bus.busy_cnt),  64'd0);
    #11;
    reset = 1'b0;

    for (int a = 0; a < 32; a++) begin
      bus.rd_addr = {5'(31 - a), 5'(a)};
      #1;
      check($sformatf("init x%0d data", a), 64'(bus.rd_data), 64'd0);
      check($sformatf("init x%0d busy", a), 64'(bus.rd_busy), 64'd0);
    end
    check("init cnt", 64'(bus.busy_cnt), 64'd0);

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk); #1;
      apply_stimulus(vq[i].wr_en, vq[i].wr_addr, vq[i].wr_data,
                     vq[i].ra0, vq[i].ra1, vq[i].iss_valid, vq[i].iss_rd);
      @(negedge clk);
      check_output($sformatf("v%0d", i), vq[i]);
    end

    // Reserve every register, then retire them all.
    for (int i = 1; i < 32; i++) begin
      @(posedge clk); #1;
      apply_stimulus(0, 0, 0, 5'(i), 0, 1, 5'(i));
      @(negedge clk);
      check($sformatf("fill ready x%0d", i), 64'(bus.iss_ready), 64'd1);
      check($sformatf("fill cnt x%0d", i),   64'(bus.busy_cnt),  64'(i - 1));
    end
    @(posedge clk); #1;
    apply_stimulus(0, 0, 0, 17, 0, 1, 17);
    @(negedge clk);
    check("full cnt",   64'(bus.busy_cnt),  64'd31);
    check("full ready", 64'(bus.iss_ready), 64'd0);
    check("full busy",  64'(bus.rd_busy),   64'b01);
    for (int i = 1; i < 32; i++) begin
      @(posedge clk); #1;
      apply_stimulus(1, 5'(i), 32'h100 + 32'(i), 0, 0, 0, 0);
      @(negedge clk);
      check($sformatf("drain cnt x%0d", i), 64'(bus.busy_cnt), 64'(32 - i));
    end
    @(posedge clk); #1;
    apply_stimulus(0, 0, 0, 20, 31, 0, 0);
    @(negedge clk);
    check("drained cnt",  64'(bus.busy_cnt), 64'd0);
    check("drained x20",  64'(bus.rd_data[31:0]),  64'h114);
    check("drained x31",  64'(bus.rd_data[63:32]), 64'h11F);
    check("drained busy", 64'(bus.rd_busy), 64'd0);

    // Asynchronous reset while four registers are reserved.
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      apply_stimulus(0, 0, 0, 0, 0, 1, 5'(2 * i));
    end
    @(posedge clk); #1;
    apply_stimulus(0, 0, 0, 2, 20, 0, 4);
    @(negedge clk);
    check("pre-rst cnt",   64'(bus.busy_cnt),  64'd4);
    check("pre-rst busy",  64'(bus.rd_busy),   64'b01);
    check("pre-rst ready", 64'(bus.iss_ready), 64'd0);
    check("pre-rst d1",    64'(bus.rd_data[63:32]), 64'h114);
    #2;
    reset = 1'b1;
    #1;
    check("mid-rst data",  64'(bus.rd_data),   64'd0);
    check("mid-rst busy",  64'(bus.rd_busy),   64'd0);
    check("mid-rst ready", 64'(bus.iss_ready), 64'd1);
    check("mid-rst cnt",   64'(bus.busy_cnt),  64'd0);
    check("mid-rst nb data", 64'(bus_nb.rd_data), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    apply_stimulus(0, 0, 0, 8, 31, 1, 8);
    @(negedge clk);
    check("post-rst data",  64'(bus.rd_data),   64'd0);
    check("post-rst ready", 64'(bus.iss_ready), 64'd1);
    check("post-rst cnt",   64'(bus.busy_cnt),  64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
